// File: rtl/axil_cmd_master_pkg.sv
// Shared definitions for the AXI4-Lite command master: FSM state encoding
// and the AXI response codes used when building host responses.
package axil_cmd_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master: converts single-word host commands into one AXI4-Lite
// transaction at a time and returns data/response on a valid/ready channel.
// Optional feature macro: AXIL_MASTER_TIMEOUT_EN - when defined, a wait for
// bvalid/rvalid longer than C_TIMEOUT_CYCLES cycles is ended with a
// synthesised SLVERR response flagged by rsp_timeout.
module axil_cmd_master
  import axil_cmd_master_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr,
  output logic                            awvalid,
  input  logic                            awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb,
  output logic                            wvalid,
  input  logic                            wready,
  input  logic [1:0]                      bresp,
  input  logic                            bvalid,
  output logic                            bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr,
  output logic                            arvalid,
  input  logic                            arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                      rresp,
  input  logic                            rvalid,
  output logic                            rready
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  state_e                          state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]               wstrb_q, wstrb_d;
  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q, w_done_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                      resp_q, resp_d;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = (C_TIMEOUT_CYCLES > 2) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Wait counter and timeout flag; cleared asynchronously with the FSM.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  // State register plus the captured command and response payload.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= AXI_RESP_OKAY;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  // Next-state and payload capture; AW and W complete independently in WR_ADDR.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
`ifdef AXIL_MASTER_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d   = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
        end
      end
      ST_WR_ADDR: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) begin
          state_d = ST_WR_RESP;
`ifdef AXIL_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          resp_d  = bresp;
          rdata_d = '0;
          state_d = ST_RSP;
        end
`ifdef AXIL_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          resp_d    = AXI_RESP_SLVERR;
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = ST_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RD_ADDR: begin
        if (arready) begin
          state_d = ST_RD_DATA;
`ifdef AXIL_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_RD_DATA: begin
        if (rvalid) begin
          rdata_d = rdata;
          resp_d  = rresp;
          state_d = ST_RSP;
        end
`ifdef AXIL_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          resp_d    = AXI_RESP_SLVERR;
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = ST_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded purely from registered state so reset drops them at once.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    awvalid   = (state_q == ST_WR_ADDR) && !aw_done_q;
    wvalid    = (state_q == ST_WR_ADDR) && !w_done_q;
    bready    = (state_q == ST_WR_RESP);
    arvalid   = (state_q == ST_RD_ADDR);
    rready    = (state_q == ST_RD_DATA);
    rsp_valid = (state_q == ST_RSP);
  end

  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

endmodule
